// File: rtl/chip8_display_scanner.sv
// chip8_display_scanner: CHIP-8 / XO-CHIP framebuffer to VGA pixel scanner.
// Lores/hires fields, integer scaling, 1-2 bitplanes, runtime RGB332 palette.
module chip8_display_scanner #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int FB_AW    = 9,
    parameter int PLANES   = 2,
    parameter int LO_SX    = 10,
    parameter int LO_SY    = 12,
    parameter int HI_SX    = 5,
    parameter int HI_SY    = 6,
    parameter int BORDER   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hires,
    input  logic [31:0]           palette,
    input  logic                  pixel_en,
    input  logic [10:0]           pixel_x,
    input  logic [10:0]           pixel_y,
    input  logic                  frame_start,
    input  logic                  line_start,
    output logic [FB_AW-1:0]      fb_addr,
    input  logic [16*PLANES-1:0]  fb_data,
    output logic [2:0]            r,
    output logic [2:0]            g,
    output logic [1:0]            b,
    output logic                  de_out
);
    localparam int CW = 8;
    localparam logic [11:0] LO_XLIM = 12'(64 * LO_SX);
    localparam logic [11:0] HI_XLIM = 12'(128 * HI_SX);

    logic             hiresQ;
    logic             synced;
    logic [6:0]       row;
    logic [FB_AW-1:0] lineBase;
    logic [CW-1:0]    vcnt;
    logic [CW-1:0]    hcnt;
    logic [3:0]       bitIdx;
    logic [15:0]      sh0;
    logic [15:0]      sh1;
    logic [1:0]       lsPipe;

    logic [CW-1:0]    sxM1;
    logic [CW-1:0]    syM1;
    logic [CW-1:0]    sxNewM1;
    logic [CW-1:0]    syNewM1;
    logic [6:0]       fieldH;
    logic [11:0]      xLim;
    logic [FB_AW-1:0] rowWords;
    logic             rowActive;
    logic             inField;
    logic             lineStart;
    logic             lineEnd;
    logic             pixStep;
    logic [15:0]      plane1Data;
    logic [1:0]       idx;
    logic             border;
    logic [7:0]       colour;

    always_comb begin
        sxM1     = hiresQ ? CW'(HI_SX - 1) : CW'(LO_SX - 1);
        syM1     = hiresQ ? CW'(HI_SY - 1) : CW'(LO_SY - 1);
        sxNewM1  = hires ? CW'(HI_SX - 1) : CW'(LO_SX - 1);
        syNewM1  = hires ? CW'(HI_SY - 1) : CW'(LO_SY - 1);
        fieldH   = hiresQ ? 7'd64 : 7'd32;
        xLim     = hiresQ ? HI_XLIM : LO_XLIM;
        rowWords = hiresQ ? FB_AW'(8) : FB_AW'(4);
    end

    assign rowActive  = row < fieldH;
    assign inField    = ({1'b0, pixel_x} < xLim) && rowActive;
    assign lineStart  = frame_start | line_start;
    assign lineEnd    = de_out & ~pixel_en;
    assign pixStep    = pixel_en & inField;
    assign plane1Data = (PLANES > 1) ? fb_data[16*PLANES-1 -: 16] : 16'h0;

    always_comb begin
        idx = 2'b00;
        if (inField) begin
            idx = {(PLANES > 1) ? sh1[15] : 1'b0, sh0[15]};
        end
        border = (BORDER != 0) &&
                 (pixel_x == 11'd0 || pixel_y == 11'd0 ||
                  pixel_x == 11'(H_ACTIVE - 1) ||
                  pixel_y == 11'(V_ACTIVE - 1));
        colour = border ? palette[31:24] : palette[{idx, 3'b000} +: 8];
    end

    // Field position: frame/line sequencing and the row counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hiresQ   <= 1'b0;
            synced   <= 1'b0;
            row      <= '0;
            lineBase <= '0;
            vcnt     <= '0;
            lsPipe   <= '0;
            de_out   <= 1'b0;
            r        <= '0;
            g        <= '0;
            b        <= '0;
        end else begin
            de_out    <= pixel_en;
            {r, g, b} <= (pixel_en && synced) ? colour : 8'h00;
            lsPipe    <= {lsPipe[0], lineStart};
            if (frame_start) begin
                hiresQ   <= hires;
                synced   <= 1'b1;
                row      <= '0;
                lineBase <= '0;
                vcnt     <= syNewM1;
            end else if (lineEnd && rowActive) begin
                if (vcnt == '0) begin
                    vcnt     <= syM1;
                    row      <= row + 7'd1;
                    lineBase <= lineBase + rowWords;
                end else begin
                    vcnt <= vcnt - CW'(1);
                end
            end
        end
    end

    // Horizontal scan: fetch, prefetch and pixel shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_addr <= '0;
            hcnt    <= '0;
            bitIdx  <= '0;
            sh0     <= '0;
            sh1     <= '0;
        end else if (lineStart) begin
            fb_addr <= frame_start ? '0 : lineBase;
            hcnt    <= frame_start ? sxNewM1 : sxM1;
            bitIdx  <= 4'd15;
        end else if (lsPipe[1] && rowActive) begin
            sh0     <= fb_data[15:0];
            sh1     <= plane1Data;
            fb_addr <= lineBase + FB_AW'(1);
        end else if (pixStep) begin
            if (hcnt != '0) begin
                hcnt <= hcnt - CW'(1);
            end else begin
                hcnt <= sxM1;
                if (bitIdx == 4'd0) begin
                    sh0     <= fb_data[15:0];
                    sh1     <= plane1Data;
                    fb_addr <= fb_addr + FB_AW'(1);
                    bitIdx  <= 4'd15;
                end else begin
                    sh0    <= {sh0[14:0], 1'b0};
                    sh1    <= {sh1[14:0], 1'b0};
                    bitIdx <= bitIdx - 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_chip8_display_scanner.sv
// tb_chip8_display_scanner: random and directed frames against a
// pixel-coordinate reference model of the scanned CHIP-8 field.
module tb_chip8_display_scanner;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        hires = 1'b0;
    logic [31:0] palette = '0;
    logic        pixel_en = 1'b0;
    logic [10:0] pixel_x = '0;
    logic [10:0] pixel_y = '0;
    logic        frame_start = 1'b0;
    logic        line_start = 1'b0;
    logic [8:0]  fb_addr;
    logic [31:0] fb_data = '0;
    logic [2:0]  r;
    logic [2:0]  g;
    logic [1:0]  b;
    logic        de_out;

    logic [15:0] mem0 [512];
    logic [15:0] mem1 [512];

    int errors = 0;
    int checks = 0;
    int frameNo = 0;
    bit checkOn = 1'b0;

    typedef struct {
        int fr;
        int x;
        int y;
        int rgb;
        int addr;
    } lit_t;
    lit_t lits[$];

    chip8_display_scanner dut (
        .clk(clk),
        .rst_n(rst_n),
        .hires(hires),
        .palette(palette),
        .pixel_en(pixel_en),
        .pixel_x(pixel_x),
        .pixel_y(pixel_y),
        .frame_start(frame_start),
        .line_start(line_start),
        .fb_addr(fb_addr),
        .fb_data(fb_data),
        .r(r),
        .g(g),
        .b(b),
        .de_out(de_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) fb_data <= {mem1[fb_addr], mem0[fb_addr]};

    function automatic logic [7:0] expColour(bit hi, int x, int y,
                                             logic [31:0] pal);
        int sx, sy, w, h, fc, word, bt;
        int idx;
        sx = hi ? 5 : 10;
        sy = hi ? 6 : 12;
        w  = hi ? 128 : 64;
        h  = hi ? 64 : 32;
        if (x == 0 || y == 0 || x == 639 || y == 479) return pal[31:24];
        idx = 0;
        if (y / sy < h && x / sx < w) begin
            fc   = x / sx;
            word = (((y / sy) * w + fc) / 16) % 512;
            bt   = 15 - fc % 16;
            idx  = 2 * int'(mem1[word][bt]) + int'(mem0[word][bt]);
        end
        return pal[idx*8 +: 8];
    endfunction

    function automatic logic [8:0] expAddr(bit hi, int x, int y);
        int sx, sy, w, h;
        sx = hi ? 5 : 10;
        sy = hi ? 6 : 12;
        w  = hi ? 128 : 64;
        h  = hi ? 64 : 32;
        if (y / sy >= h) return 9'((h * w / 16) % 512);
        return 9'(((y / sy) * w / 16 + 1 + (x + 1) / (16 * sx)) % 512);
    endfunction

    logic [7:0] eRgb;
    logic       eDe;
    logic       eAddrOk;
    logic [8:0] eAddr;
    int         eX, eY, eFr;
    bit         mHi, mSync;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mHi     <= 1'b0;
            mSync   <= 1'b0;
            eRgb    <= '0;
            eDe     <= 1'b0;
            eAddrOk <= 1'b0;
            eAddr   <= '0;
        end else begin
            if (frame_start) begin
                mHi   <= hires;
                mSync <= 1'b1;
            end
            eDe     <= pixel_en;
            eRgb    <= (pixel_en && mSync) ?
                       expColour(mHi, int'(pixel_x), int'(pixel_y), palette) : 8'h00;
            eAddrOk <= pixel_en && mSync;
            eAddr   <= expAddr(mHi, int'(pixel_x), int'(pixel_y));
            eX      <= int'(pixel_x);
            eY      <= int'(pixel_y);
            eFr     <= frameNo;
        end
    end

    task automatic check(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h x=%0d y=%0d frame=%0d t=%0t",
                     nm, act, exp, eX, eY, eFr, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkOn) begin
            check("de_out", int'(de_out), int'(eDe));
            check("rgb", int'({r, g, b}), int'(eRgb));
            if (eAddrOk) begin
                check("fb_addr", int'(fb_addr), int'(eAddr));
                foreach (lits[i]) begin
                    if (lits[i].fr == eFr && lits[i].x == eX && lits[i].y == eY) begin
                        check("lit_rgb", int'({r, g, b}), lits[i].rgb);
                        check("lit_addr", int'(fb_addr), lits[i].addr);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doLine(int y, int len, bit fs, bit randPal, int rstX);
        line_start  = 1'b1;
        frame_start = fs;
        tick();
        line_start  = 1'b0;
        frame_start = 1'b0;
        repeat (3) tick();
        for (int x = 0; x < len; x++) begin
            pixel_en = 1'b1;
            pixel_x  = 11'(x);
            pixel_y  = 11'(y);
            if (randPal && $urandom_range(63) == 0) palette = $urandom;
            if (x == rstX) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_rgb", int'({r, g, b}), 0);
                check("rst_de", int'(de_out), 0);
                check("rst_addr", int'(fb_addr), 0);
                tick();
                tick();
                rst_n = 1'b1;
            end
            tick();
        end
        pixel_en = 1'b0;
        tick();
    endtask

    task automatic doFrame(bit hi, bit coinc, int nLines, int toggleY,
                           int rstY, bit randPal);
        hires = hi;
        frameNo++;
        if (!coinc) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            tick();
        end
        for (int y = 0; y < nLines; y++) begin
            int len;
            if (y == toggleY) hires = ~hires;
            len = (y inside {0, 5, 12, 383, 384, 479} || y == rstY) ?
                  640 : 8 + $urandom_range(4);
            doLine(y, len, coinc && y == 0, randPal, (y == rstY) ? 300 : -1);
        end
    endtask

    task automatic randMem();
        for (int i = 0; i < 512; i++) begin
            mem0[i] = 16'($urandom);
            mem1[i] = 16'($urandom);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        lits.push_back('{1, 5, 5, 'hFF, 1});
        lits.push_back('{1, 9, 5, 'hFF, 1});
        lits.push_back('{1, 10, 5, 'h00, 1});
        lits.push_back('{1, 0, 5, 'h03, 1});
        lits.push_back('{1, 159, 5, 'h00, 2});
        lits.push_back('{1, 319, 5, 'h00, 3});
        lits.push_back('{1, 639, 5, 'h03, 5});
        lits.push_back('{1, 5, 12, 'h00, 5});
        lits.push_back('{1, 5, 384, 'h00, 128});
        lits.push_back('{2, 1, 5, 'h1C, 1});
        lits.push_back('{2, 638, 383, 'h1C, 0});
        lits.push_back('{2, 639, 5, 'hE0, 9});
        lits.push_back('{2, 5, 384, 'h00, 0});
        lits.push_back('{2, 5, 479, 'hE0, 0});
        lits.push_back('{3, 0, 5, 'h33, 1});
        lits.push_back('{3, 5, 5, 'h11, 1});
        lits.push_back('{3, 15, 5, 'h33, 1});
        lits.push_back('{3, 25, 5, 'h11, 1});
        lits.push_back('{3, 165, 5, 'h11, 2});

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rgb", int'({r, g, b}), 0);
        check("reset_de", int'(de_out), 0);
        check("reset_addr", int'(fb_addr), 0);
        rst_n   = 1'b1;
        checkOn = 1'b1;
        palette = 32'hFFFFFFFF;
        doLine(0, 10, 1'b0, 1'b0, -1);

        mem0[0] = 16'h8000;
        palette = 32'h0322FF00;
        doFrame(1'b0, 1'b0, 480, -1, -1, 1'b0);

        for (int i = 0; i < 512; i++) mem0[i] = 16'hFFFF;
        palette = 32'hE0001C00;
        doFrame(1'b1, 1'b0, 480, -1, -1, 1'b0);

        mem1[0] = 16'h5555;
        palette = 32'h33221100;
        doFrame(1'b0, 1'b0, 480, -1, -1, 1'b0);

        randMem();
        palette = $urandom;
        doFrame(1'b0, 1'b0, 480, 100, -1, 1'b1);
        doFrame(1'b1, 1'b1, 480, -1, -1, 1'b1);
        doFrame(1'b0, 1'b0, 210, -1, 200, 1'b1);

        randMem();
        doFrame(1'($urandom_range(1)), 1'b0, 480, -1, -1, 1'b1);

        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
